prng_xorshift_core: RTL

PRNG_XORSHIFT_CORE -- requirements
Module: prng_xorshift_core

---
 rtl/prng_xorshift_core.sv | 87 ++++++++
 1 files changed

// File: rtl/prng_xorshift_core.sv
// Byte-serial xorshift32 random number generator with a little-endian 4-byte
// reseed port and a valid/ready output handshake.
module prng_xorshift_core #(
  parameter logic [31:0] DEFAULT_SEED = 32'h2545_F491
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] seed_in,
  input  logic       seed_valid,
  output logic [7:0] rnd_data,
  output logic       rnd_valid,
  input  logic       rnd_ready,
  output logic       loading
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_x;
  logic [1:0]  r_idx;
  logic [31:0] r_sh;
  logic [1:0]  r_cnt;
  logic [7:0]  r_rnd_data;
  logic        r_rnd_valid;

  logic [31:0] w_x1;
  logic [31:0] w_x2;
  logic [31:0] w_x_next;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic        w_slot_free;

  // Xorshift32 step (13, 17, 5); shifted-out bits are simply dropped.
  assign w_x1     = r_x ^ (r_x << 13);
  assign w_x2     = w_x1 ^ (w_x1 >> 17);
  assign w_x_next = w_x2 ^ (w_x2 << 5);

  // Seed bytes arrive LSB first, so each new byte enters at the top.
  assign w_word      = {seed_in, r_sh[31:8]};
  assign w_byte      = r_x[{r_idx, 3'b000} +: 8];
  assign w_slot_free = !r_rnd_valid || rnd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_x         <= DEFAULT_SEED;
      r_idx       <= 2'd0;
      r_sh        <= 32'd0;
      r_cnt       <= 2'd0;
      r_rnd_data  <= 8'h00;
      r_rnd_valid <= 1'b0;
    end else if (ena) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, regardless of statement order.
      if (seed_valid) begin
        // A seed byte always wins; any pending output byte is dropped.
        r_sh        <= w_word;
        r_rnd_valid <= 1'b0;
        if (r_cnt == 2'd3) begin
          r_x     <= (w_word == 32'd0) ? DEFAULT_SEED : w_word;
          r_idx   <= 2'd0;
          r_cnt   <= 2'd0;
          r_state <= ST_RUN;
        end else begin
          r_cnt   <= r_cnt + 2'd1;
          r_state <= ST_LOAD;
        end
      end else if (r_state == ST_RUN && w_slot_free) begin
        r_rnd_data  <= w_byte;
        r_rnd_valid <= 1'b1;
        r_idx       <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_x <= w_x_next;
        end
      end
    end
  end

  assign rnd_data  = r_rnd_data;
  assign rnd_valid = r_rnd_valid;
  assign loading   = (r_state == ST_LOAD);

endmodule
